// File: rtl/hazard_unit.sv
// ============================================================================
// hazard_unit
// ----------------------------------------------------------------------------
// Pipeline hazard controller for a classic IF/ID/EX/MEM pipeline.
//
// Handles three hazard sources:
//   * taken branch/jump resolved in EX/MEM: flush IF/ID and bubble ID/EX.
//     This is honoured in every state and squashes any multiply in flight.
//   * multi-cycle multiply: freezes the front end and injects bubbles into
//     EX/MEM for MUL_LATENCY cycles counted from the mul_start cycle.
//   * load-use: a load in ID/EX whose destination feeds the instruction in
//     IF/ID stalls PC and IF/ID for one cycle and bubbles ID/EX.
// Priority: branch flush > multiply > load-use.
//
// Parameters
//   MUL_LATENCY         EX cycles a multiply occupies (legal range 2..16)
//
// Ports
//   clk                 rising-edge clock
//   arst_n              synchronous active-low reset (sampled on rising clk)
//   register_rs1_IFID   rs1 of the instruction in IF/ID
//   register_rs2_IFID   rs2 of the instruction in IF/ID
//   use_rs1_IFID        that instruction really reads rs1
//   use_rs2_IFID        that instruction really reads rs2
//   register_rd_IDEX    destination of the instruction in ID/EX
//   mem_read_IDEX       the instruction in ID/EX is a load
//   mul_start_IDEX      the instruction in ID/EX is a multiply entering EX
//   branch_taken_EXMEM  branch/jump in EX/MEM resolved taken
//   pc_write            PC update enable
//   ifid_write          IF/ID register enable
//   idex_write          ID/EX register enable
//   ifid_flush          replace IF/ID contents with a NOP
//   idex_bubble         load a NOP into ID/EX
//   exmem_bubble        load a NOP into EX/MEM
//   mul_busy            a multiply is occupying EX
//   stall_cycles        (HAZARD_PERF_CNT_EN only) saturating count of cycles
//                       with pc_write low
//
// Build option
//   HAZARD_PERF_CNT_EN  when defined, adds the stall_cycles counter and port.
//
// Handshake note: every enable/bubble output is a same-cycle combinational
// function of the registered FSM state and the current pipeline inputs; the
// pipeline registers consume them on the next rising clk edge.
// ============================================================================
module hazard_unit #(
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic [4:0]  register_rs1_IFID,
    input  logic [4:0]  register_rs2_IFID,
    input  logic        use_rs1_IFID,
    input  logic        use_rs2_IFID,
    input  logic [4:0]  register_rd_IDEX,
    input  logic        mem_read_IDEX,
    input  logic        mul_start_IDEX,
    input  logic        branch_taken_EXMEM,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        exmem_bubble,
    output logic        mul_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    // The start cycle itself is the first of the MUL_LATENCY cycles, so the
    // busy phase lasts MUL_LATENCY-1 cycles (counter value MUL_LATENCY-1 .. 1).
    localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

    state_e     state_q;
    logic [3:0] mul_cnt_q;

    logic       load_use;
    logic       rs1_match;
    logic       rs2_match;

    // ------------------------------------------------------------------------
    // Load-use detection. x0 is hard-wired zero, so a load targeting it can
    // never create a true dependency.
    // ------------------------------------------------------------------------
    assign rs1_match = use_rs1_IFID && (register_rd_IDEX == register_rs1_IFID);
    assign rs2_match = use_rs2_IFID && (register_rd_IDEX == register_rs2_IFID);
    assign load_use  = mem_read_IDEX && (register_rd_IDEX != 5'd0)
                       && (rs1_match || rs2_match);

    // ------------------------------------------------------------------------
    // FSM: state and multiply down-counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= 4'd0;
        end else if (branch_taken_EXMEM) begin
            // A taken branch kills whatever is in EX, including a multiply.
            state_q   <= ST_RUN;
            mul_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mul_start_IDEX) begin
                        state_q   <= ST_MUL_BUSY;
                        mul_cnt_q <= MUL_LOAD;
                    end
                end
                ST_MUL_BUSY: begin
                    // mul_start_IDEX is ignored here: the frozen ID/EX still
                    // holds the multiply that is already executing. The <=
                    // also recovers cleanly if the counter were ever 0.
                    if (mul_cnt_q <= 4'd1) begin
                        state_q   <= ST_RUN;
                        mul_cnt_q <= 4'd0;
                    end else begin
                        mul_cnt_q <= mul_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q   <= ST_RUN;
                    mul_cnt_q <= 4'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode.
    // ------------------------------------------------------------------------
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        mul_busy     = 1'b0;

        if (branch_taken_EXMEM) begin
            // Redirect fetch and drop the two wrong-path instructions.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == ST_MUL_BUSY) begin
            // Freeze the front end; load-use is re-evaluated once back in RUN.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            mul_busy     = 1'b1;
        end else if (mul_start_IDEX) begin
            // The multiply enters EX normally in its start cycle.
            pc_write = 1'b1;
        end else if (load_use) begin
            // One bubble suffices: next cycle ID/EX holds the NOP, so the
            // comparison no longer matches and the stall releases itself.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Saturating front-end stall counter.
    // ------------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit. Inputs change just after the falling edge,
// outputs are sampled 1 time unit later, state advances on the rising edge.
module tb_hazard_unit;

    localparam int L = 4;

    logic        clk;
    logic        arst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, mem_read, mul_start, branch;
    logic        pc_write, ifid_write, idex_write;
    logic        ifid_flush, idex_bubble, exmem_bubble, mul_busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit #(.MUL_LATENCY(L)) dut (
        .clk                (clk),
        .arst_n             (arst_n),
        .register_rs1_IFID  (rs1),
        .register_rs2_IFID  (rs2),
        .use_rs1_IFID       (use1),
        .use_rs2_IFID       (use2),
        .register_rd_IDEX   (rd),
        .mem_read_IDEX      (mem_read),
        .mul_start_IDEX     (mul_start),
        .branch_taken_EXMEM (branch),
        .pc_write           (pc_write),
        .ifid_write         (ifid_write),
        .idex_write         (idex_write),
        .ifid_flush         (ifid_flush),
        .idex_bubble        (idex_bubble),
        .exmem_bubble       (exmem_bubble),
        .mul_busy           (mul_busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles       (stall_cycles)
`endif
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mul_busy}
    logic [6:0] obs;
    assign obs = {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, exmem_bubble, mul_busy};

    localparam logic [6:0] O_IDLE  = 7'b1110000;
    localparam logic [6:0] O_LU    = 7'b0010100;
    localparam logic [6:0] O_BUSY  = 7'b0000011;

    // Reference model: number of busy cycles still to come (0 = running).
    int          m_rem;
    logic [31:0] m_stall;

    function automatic logic model_load_use();
        return mem_read && (rd != 5'd0) &&
               ((use1 && rd == rs1) || (use2 && rd == rs2));
    endfunction

    // Expected outputs plus a mask of the bits the rules actually define.
    task automatic model_out(output logic [6:0] e, output logic [6:0] m);
        m = 7'b1111111;
        if (branch) begin
            e = 7'b1000000 | 7'b0001100;
            m = 7'b1001100;               // pc_write, ifid_flush, idex_bubble
        end else if (m_rem > 0) e = O_BUSY;
        else if (mul_start)     e = O_IDLE;
        else if (model_load_use()) e = O_LU;
        else                    e = O_IDLE;
    endtask

    task automatic model_step(input logic pcw);
        if (!arst_n || branch) m_rem = 0;
        else if (m_rem > 0)    m_rem = m_rem - 1;
        else if (mul_start)    m_rem = L - 1;
        if (!arst_n) m_stall = 32'd0;
        else if (!pcw && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    endtask

    // driver tasks
    task automatic drive_idle();
        arst_n = 1'b1; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mem_read = 1'b0; mul_start = 1'b0; branch = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        m_rem = 0;
        m_stall = 32'd0;
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        drive_idle();
        arst_n = 1'b0;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL reset_outputs got=%b want=%b", obs, O_IDLE);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall_cycles got=%h want=0", stall_cycles);
        end
`endif
    endtask

    task automatic test_load_use();
        do_reset();
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_LU) begin
            n_err++;
            $display("FAIL load_use_stall got=%b want=%b", obs, O_LU);
        end
        // Next cycle ID/EX holds the bubble: no longer a load.
        @(negedge clk);
        mem_read = 1'b0; rd = 5'd0;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL load_use_release got=%b want=%b", obs, O_IDLE);
        end
        // rs2 path
        @(negedge clk);
        mem_read = 1'b1; rd = 5'd9; rs1 = 5'd1; rs2 = 5'd9; use1 = 1'b1; use2 = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_LU) begin
            n_err++;
            $display("FAIL load_use_rs2 got=%b want=%b", obs, O_LU);
        end
        // match but operand unused
        @(negedge clk);
        use2 = 1'b0;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL load_use_unused got=%b want=%b", obs, O_IDLE);
        end
        // x0 never hazardous
        @(negedge clk);
        rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; use1 = 1'b1; use2 = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL load_use_x0 got=%b want=%b", obs, O_IDLE);
        end
    endtask

    task automatic test_multiply();
        do_reset();
        mul_start = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL mul_start_cycle got=%b want=%b", obs, O_IDLE);
        end
        // ID/EX keeps the multiply while frozen, so mul_start stays high.
        for (int i = 1; i < L; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (obs !== O_BUSY) begin
                n_err++;
                $display("FAIL mul_busy_cycle%0d got=%b want=%b", i, obs, O_BUSY);
            end
        end
        @(negedge clk);
        mul_start = 1'b0;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL mul_done got=%b want=%b", obs, O_IDLE);
        end
    endtask

    task automatic test_branch_during_mul();
        do_reset();
        mul_start = 1'b1;
        @(negedge clk);                   // busy, count 3
        @(negedge clk);                   // busy, count 2
        branch = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ifid_flush, idex_bubble} !== 3'b111) begin
            n_err++;
            $display("FAIL branch_in_mul got=%b want=111", {pc_write, ifid_flush, idex_bubble});
        end
        @(negedge clk);
        branch = 1'b0; mul_start = 1'b0;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL branch_in_mul_after got=%b want=%b", obs, O_IDLE);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
        mul_start = 1'b1; branch = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ifid_flush, idex_bubble, mul_busy} !== 4'b1110) begin
            n_err++;
            $display("FAIL simultaneous got=%b want=1110", {pc_write, ifid_flush, idex_bubble, mul_busy});
        end
        @(negedge clk);
        drive_idle();
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL simultaneous_stay_run got=%b want=%b", obs, O_IDLE);
        end
    endtask

    task automatic test_reset_mid_mul();
        do_reset();
        mul_start = 1'b1;
        @(negedge clk);
        @(negedge clk);                   // count 2
        mul_start = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_IDLE) begin
            n_err++;
            $display("FAIL reset_mid_mul got=%b want=%b", obs, O_IDLE);
        end
    endtask

    task automatic test_random();
        logic [6:0] e, m;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            arst_n    = ($urandom_range(0, 39) != 0);
            rd        = 5'($urandom_range(0, 3));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            use1      = 1'($urandom_range(0, 1));
            use2      = 1'($urandom_range(0, 1));
            mem_read  = 1'($urandom_range(0, 1));
            mul_start = ($urandom_range(0, 5) == 0);
            branch    = ($urandom_range(0, 11) == 0);
            #1;
            model_out(e, m);
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL random_c%0d got=%b want=%b mask=%b", c, obs, e, m);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_cmp++;
            if (stall_cycles !== m_stall) begin
                n_err++;
                $display("FAIL random_stall_c%0d got=%0d want=%0d", c, stall_cycles, m_stall);
            end
`endif
            model_step(e[6]);
        end
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_sat();
        do_reset();
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        mem_read = 1'b1; rd = 5'd7; rs1 = 5'd7; use1 = 1'b1;
        repeat (3) @(negedge clk);
        drive_idle();
        #1;
        n_cmp++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL perf_saturate got=%h want=ffffffff", stall_cycles);
        end
    endtask
`endif

    initial begin
        m_rem = 0;
        m_stall = 32'd0;
        test_reset();
        test_load_use();
        test_multiply();
        test_branch_during_mul();
        test_simultaneous();
        test_reset_mid_mul();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_sat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
